// File: rtl/fabric_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : fabric_config_loader
// Brief    : Frames a byte-wide config bitstream, shifts it MSB-first onto the
//            fabric scan chain and commits it only when the checksum matches.
// Revision : 1.0 - initial release
// ============================================================================
module fabric_config_loader #(
  parameter int         CHAIN_LEN = 1024,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 4096
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       cfg_shift,
  output logic       cfg_bit,
  output logic       cfg_commit,
  output logic       fabric_rst,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int c_n_bytes = CHAIN_LEN / 8;
  localparam int c_bw      = $clog2(c_n_bytes + 1);
  localparam int c_iw      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_bw-1:0] c_byte_last = c_bw'(c_n_bytes);
  localparam logic [c_iw-1:0] c_idle_last = c_iw'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CHECK  = 3'd2,
    S_COMMIT = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t          r_state;
  logic [7:0]      r_shreg;
  logic [3:0]      r_shcnt;
  logic [7:0]      r_acc;
  logic [c_bw-1:0] r_byte_cnt;
  logic [c_iw-1:0] r_idle_cnt;
  logic            r_commit;
  logic            r_fabric_rst;
  logic            r_busy;
  logic            r_done;
  logic            r_error;

  logic w_ready;
  logic w_xfer;
  logic w_payload_full;
  logic w_idle_tick;
  logic w_timeout;

  assign w_payload_full = (r_byte_cnt == c_byte_last);

  // In LOAD the next byte is taken on the last shift cycle so bytes stream
  // back-to-back at 8 cycles each.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_IDLE, S_CHECK: w_ready = 1'b1;
      S_LOAD:          w_ready = !w_payload_full && (r_shcnt <= 4'd1);
      default:         w_ready = 1'b0;
    endcase
    if (reset) begin
      w_ready = 1'b0;
    end
  end

  assign w_xfer      = s_valid && w_ready;
  assign w_idle_tick = ((r_state == S_LOAD) || (r_state == S_CHECK)) && w_ready && !s_valid;
  assign w_timeout   = (TIMEOUT != 0) && w_idle_tick && (r_idle_cnt == c_idle_last);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_shcnt      <= '0;
      r_acc        <= '0;
      r_byte_cnt   <= '0;
      r_idle_cnt   <= '0;
      r_commit     <= 1'b0;
      r_fabric_rst <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_commit <= 1'b0;

      if (w_xfer) begin
        r_idle_cnt <= '0;
      end else if (w_idle_tick && !w_timeout && (TIMEOUT != 0)) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_xfer && (s_data == SYNC_BYTE)) begin
            r_state      <= S_LOAD;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_acc        <= '0;
            r_byte_cnt   <= '0;
            r_fabric_rst <= 1'b1;
            r_busy       <= 1'b1;
          end
        end

        S_LOAD: begin
          if (w_xfer) begin
            r_shreg    <= s_data;
            r_shcnt    <= 4'd8;
            r_acc      <= r_acc ^ s_data;
            r_byte_cnt <= r_byte_cnt + 1'b1;
          end else if (r_shcnt != 4'd0) begin
            r_shreg <= {r_shreg[6:0], 1'b0};
            r_shcnt <= r_shcnt - 1'b1;
          end
          // A timeout can only land on the final shift cycle, so clearing
          // the count here never truncates a bit mid-flight.
          if (w_timeout) begin
            r_state <= S_ERROR;
            r_shcnt <= '0;
          end else if (w_payload_full && (r_shcnt == 4'd0)) begin
            r_state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (w_timeout) begin
            r_state <= S_ERROR;
          end else if (w_xfer) begin
            if (s_data == r_acc) begin
              r_state  <= S_COMMIT;
              r_commit <= 1'b1;
            end else begin
              r_state <= S_ERROR;
            end
          end
        end

        S_COMMIT: begin
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
          r_fabric_rst <= 1'b0;
          r_state      <= S_IDLE;
        end

        S_ERROR: begin
          r_error <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ready    = w_ready;
  assign cfg_shift  = (r_shcnt != 4'd0);
  assign cfg_bit    = cfg_shift & r_shreg[7];
  assign cfg_commit = r_commit;
  assign fabric_rst = r_fabric_rst;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_fabric_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fabric_config_loader
// Brief    : Scoreboard bench for fabric_config_loader (CHAIN_LEN=16, TIMEOUT=20).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fabric_config_loader;

  localparam int CHAIN_LEN = 16;
  localparam int TIMEOUT   = 20;
  localparam int NB        = CHAIN_LEN / 8;

  logic       clock;
  logic       reset;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       cfg_shift;
  logic       cfg_bit;
  logic       cfg_commit;
  logic       fabric_rst;
  logic       busy;
  logic       done;
  logic       error;

  fabric_config_loader #(
    .CHAIN_LEN (CHAIN_LEN),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (TIMEOUT)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .cfg_shift  (cfg_shift),
    .cfg_bit    (cfg_bit),
    .cfg_commit (cfg_commit),
    .fabric_rst (fabric_rst),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  typedef struct packed {
    logic b;
    logic rdy;
  } shift_exp_t;

  shift_exp_t q_shift[$];
  int         q_commit[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         shift_runs = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected shift bits and commit events as the DUT emits them.
  initial begin
    shift_exp_t e;
    logic prev_shift;
    logic chk_rst_after;
    prev_shift    = 1'b0;
    chk_rst_after = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (chk_rst_after) begin
          check("fabric_rst_after_commit", fabric_rst, 1'b0);
          chk_rst_after = 1'b0;
        end
        if (cfg_shift) begin
          if (!prev_shift) shift_runs++;
          if (q_shift.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_shift: got cfg_shift=1 expected no further shift");
          end else begin
            e = q_shift.pop_front();
            check("cfg_bit", cfg_bit, e.b);
            check("s_ready_in_shift", s_ready, e.rdy);
          end
        end else begin
          check("cfg_bit_idle", cfg_bit, 1'b0);
        end
        if (cfg_commit) begin
          if (q_commit.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_commit: got cfg_commit=1 expected 0");
          end else begin
            void'(q_commit.pop_front());
            check("shifts_done_at_commit", q_shift.size(), 0);
            check("fabric_rst_during_commit", fabric_rst, 1'b1);
            chk_rst_after = 1'b1;
          end
        end
      end
      prev_shift = cfg_shift;
    end
  end

  task automatic send_byte(input logic [7:0] v);
    int t;
    s_valid = 1'b1;
    s_data  = v;
    t = 0;
    while (!s_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!s_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got s_ready=0 expected 1 within 200 cycles");
    end else begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic payload(input logic [7:0] v, input int idx);
    for (int i = 0; i < 8; i++) begin
      q_shift.push_back('{b: v[7-i], rdy: (i == 7) && (idx < NB - 1)});
    end
    send_byte(v);
  endtask

  task automatic gap(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_end();
    int t;
    s_valid = 1'b0;
    t = 0;
    while ((busy || !(done || error)) && t < 300) begin
      @(negedge clock);
      t++;
    end
    check("frame_end_reached", (t < 300), 1'b1);
  endtask

  task automatic good_frame();
    send_byte(8'hA5);
    payload(8'h3C, 0);
    payload(8'h81, 1);
    q_commit.push_back(1);
    send_byte(8'hBD);
    wait_end();
  endtask

  task automatic check_committed(input string tag);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_fabric_rst"}, fabric_rst, 1'b0);
    check({tag, "_commit_seen"}, q_commit.size(), 0);
    check({tag, "_all_shifts"}, q_shift.size(), 0);
  endtask

  initial begin
    int cnt;
    int t;
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (2) @(negedge clock);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_cfg_shift", cfg_shift, 1'b0);
    check("rst_cfg_bit", cfg_bit, 1'b0);
    check("rst_cfg_commit", cfg_commit, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_fabric_rst", fabric_rst, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    check("idle_s_ready", s_ready, 1'b1);

    // Good frame, back-to-back: one contiguous run of 16 shifts.
    shift_runs = 0;
    good_frame();
    check_committed("good");
    check("good_contiguous", shift_runs, 1);

    // Bad checksum.
    send_byte(8'hA5);
    payload(8'h3C, 0);
    payload(8'h81, 1);
    send_byte(8'h00);
    wait_end();
    check("badck_error", error, 1'b1);
    check("badck_done", done, 1'b0);
    check("badck_fabric_rst", fabric_rst, 1'b1);
    check("badck_all_shifts", q_shift.size(), 0);

    // Pre-sync garbage is discarded without shifting; sticky error survives it.
    shift_runs = 0;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    gap(2);
    check("garbage_busy", busy, 1'b0);
    check("garbage_error_sticky", error, 1'b1);
    check("garbage_no_shift", shift_runs, 0);
    good_frame();
    check_committed("garbage");
    check("garbage_contiguous", shift_runs, 1);

    // Backpressure and gaps mid-payload.
    send_byte(8'hA5);
    gap(2);
    payload(8'h3C, 0);
    gap(10);
    payload(8'h81, 1);
    gap(3);
    q_commit.push_back(1);
    send_byte(8'hBD);
    wait_end();
    check_committed("gaps");

    // Timeout after the first payload byte.
    send_byte(8'hA5);
    payload(8'h3C, 0);
    gap(1);
    wait_end();
    check("tmo_error", error, 1'b1);
    check("tmo_done", done, 1'b0);
    check("tmo_busy", busy, 1'b0);
    check("tmo_fabric_rst", fabric_rst, 1'b1);
    check("tmo_eight_shifts", q_shift.size(), 0);

    // Reset after 5 shift cycles.
    send_byte(8'hA5);
    payload(8'h3C, 0);
    s_valid = 1'b0;
    cnt = 0;
    t = 0;
    while (cnt < 5 && t < 100) begin
      if (cfg_shift) cnt++;
      if (cnt < 5) @(negedge clock);
      t++;
    end
    check("midrst_reached_5", cnt, 5);
    @(posedge clock);
    #1;
    reset = 1'b1;
    check("midrst_five_shifts", q_shift.size(), 3);
    q_shift.delete();
    #1;
    check("midrst_cfg_shift", cfg_shift, 1'b0);
    check("midrst_cfg_bit", cfg_bit, 1'b0);
    check("midrst_fabric_rst", fabric_rst, 1'b1);
    check("midrst_done", done, 1'b0);
    check("midrst_error", error, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_s_ready", s_ready, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_fabric_rst_held", fabric_rst, 1'b1);
    good_frame();
    check_committed("after_rst");

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
